// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI link blocks (master and slave side).
//   SPI_WIDTH   : default frame length in bits
//   spi_state_e : frame state, IDLE (ss high) / ACTIVE (frame window open)
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Brings one asynchronous SPI line into the clk domain and derives its edges.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input line
//   level      : synchronized level (history flop)
//   rise, fall : one-cycle edge pulses, aligned with level
// Parameters:
//   SYNC_STAGES : synchronizer depth (>= 2)
//   RESET_VAL   : idle level of the line, loaded into every flop on reset
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Edges are registered from the synced/history pair so they line up
  // with the history flop that is presented as the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  assign level = hist_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave
// SPI mode-0 responder, oversampled in the clk domain. MSB-first frames are
// deserialized into rx_data; a one-entry transmit buffer feeds miso.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   sck, mosi, ss       : SPI bus from the master (ss active-low)
//   miso                : serial data to the master, 0 while idle
//   tx_data/valid/ready : load port for the next frame's transmit byte
//   rx_data/valid/ack   : last received frame, held until acknowledged
//   busy                : frame window open
// Optional build macro SPI_SLAVE_STATUS_EN adds:
//   clr_status          : clears both sticky flags (a set in the same cycle wins)
//   overrun             : a frame completed while rx_valid was still set
//   underrun            : a transmit load found the buffer empty
//
// state  | meaning
// IDLE   | ss high, miso driven 0, sck ignored
// ACTIVE | ss low, shifting frames; one buffer load per frame
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             mosi,
  input  logic             ss,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic             clr_status,
  output logic             overrun,
  output logic             underrun
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  spi_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-1:0] tx_buf_q;

  logic sck_rise, sck_fall, sck_level_unused;
  logic ss_rise, ss_fall, ss_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  logic             frame_done;
  logic             load_evt;
  logic [WIDTH-1:0] load_val;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss),
    .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // ss rising ends the window and takes priority over any coincident sck edge.
  always_comb begin
    frame_done = (state_q == ACTIVE) && !ss_rise && sck_rise && (count_q == LAST_BIT);
    load_evt   = ((state_q == IDLE) && ss_fall) || frame_done;
    load_val   = tx_ready ? '0 : tx_buf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            count_q    <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= load_val;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (sck_rise) begin
            rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_level};
            if (count_q == LAST_BIT) begin
              rx_data    <= {rx_shift_q[WIDTH-2:0], mosi_level};
              count_q    <= '0;
              tx_shift_q <= load_val;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end else if (sck_fall && (count_q != '0)) begin
            // count == 0 right after a reload: the new MSB must stay on miso
            tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A load samples the buffer before a same-cycle write, so the write always
  // lands in the buffer for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf_q <= '0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
    end else begin
      if (load_evt) tx_ready <= 1'b1;
      if (tx_valid && tx_ready) begin
        tx_buf_q <= tx_data;
        tx_ready <= 1'b0;
      end
      if (frame_done) rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;
    end
  end

  assign miso = (state_q == ACTIVE) ? tx_shift_q[WIDTH-1] : 1'b0;
  assign busy = (state_q == ACTIVE);

`ifdef SPI_SLAVE_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // an ack arriving with the completing frame means the old data was read
      if (frame_done && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (load_evt && tx_ready) underrun <= 1'b1;
      else if (clr_status) underrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave
// Self-checking bench for spi_slave: acts as a mode-0 SPI master and keeps a
// transaction-level model of the transmit buffer and receive register.
// Define SPI_SLAVE_STATUS_EN to also check the sticky status flags.
module tb_spi_slave;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int HP = 8;

  logic         clk;
  logic         reset;
  logic         sck, mosi, ss, miso;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_ack, busy;
`ifdef SPI_SLAVE_STATUS_EN
  logic         clr_status, overrun, underrun;
`endif

  spi_slave #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy)
`ifdef SPI_SLAVE_STATUS_EN
    , .clr_status(clr_status), .overrun(overrun), .underrun(underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic         m_tx_full = 1'b0;
  logic [W-1:0] m_tx_buf  = '0;
  logic [W-1:0] m_cur_tx  = '0;
  logic         m_rx_valid = 1'b0;
  logic [W-1:0] m_rx_data  = '0;
  logic         m_over = 1'b0;
  logic         m_under = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_load(output logic [W-1:0] v);
    v = m_tx_full ? m_tx_buf : '0;
    if (!m_tx_full) m_under = 1'b1;
    m_tx_full = 1'b0;
  endtask

  task automatic write_tx(input logic [W-1:0] v);
    check("tx_ready", 32'(tx_ready), 32'(!m_tx_full));
    tx_valid = 1'b1;
    tx_data  = v;
    if (!m_tx_full) begin
      m_tx_full = 1'b1;
      m_tx_buf  = v;
    end
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic ss_open();
    ss = 1'b0;
    model_load(m_cur_tx);
    tick(HP);
    check("busy_open", 32'(busy), 32'd1);
    check("tx_ready_load", 32'(tx_ready), 32'(!m_tx_full));
  endtask

  task automatic ss_close();
    ss = 1'b1;
    tick(HP);
    check("busy_close", 32'(busy), 32'd0);
    check("miso_idle", 32'(miso), 32'd0);
    check("rx_valid_close", 32'(rx_valid), 32'(m_rx_valid));
    check("rx_data_close", 32'(rx_data), 32'(m_rx_data));
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    m_rx_valid = 1'b0;
    tick(1);
    check("rx_valid_ack", 32'(rx_valid), 32'd0);
  endtask

  // One frame (or n_bits < W for a truncated one) with ss already low.
  task automatic spi_frame(input logic [W-1:0] mo, input int n_bits, input bit do_wr,
                           input logic [W-1:0] wr_v, input bit ack);
    logic [W-1:0] mi;
    logic [W-1:0] exp_tx;
    int k;
    mi = '0;
    exp_tx = m_cur_tx;
    for (int i = 0; i < n_bits; i++) begin
      mosi = mo[W-1-i];
      tick(HP);
      sck = 1'b1;
      mi[W-1-i] = miso;
      if (i == W-1 && !m_rx_valid) begin
        k = 0;
        do begin
          tick(1);
          k++;
        end while (!rx_valid && k < HP);
        check("rx_latency", 32'(k), 32'(S + 2));
        if (k < HP) tick(HP - k);
      end else if (do_wr && i == 3) begin
        write_tx(wr_v);
        tick(HP - 1);
      end else begin
        tick(HP);
      end
      sck = 1'b0;
    end
    if (n_bits == W) begin
      if (m_rx_valid) m_over = 1'b1;
      m_rx_valid = 1'b1;
      m_rx_data  = mo;
      model_load(m_cur_tx);
      check("miso_byte", 32'(mi), 32'(exp_tx));
      check("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
      check("rx_data", 32'(rx_data), 32'(m_rx_data));
      if (ack) do_ack();
    end
  endtask

  task automatic check_status();
`ifdef SPI_SLAVE_STATUS_EN
    check("overrun", 32'(overrun), 32'(m_over));
    check("underrun", 32'(underrun), 32'(m_under));
    if ($urandom_range(1) == 1) begin
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      m_over  = 1'b0;
      m_under = 1'b0;
      tick(1);
      check("status_clr", 32'({overrun, underrun}), 32'd0);
    end
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SPI_SLAVE_STATUS_EN
    check({tag, "_status"}, 32'({overrun, underrun}), 32'd0);
`endif
  endtask

  initial begin
    int nf;
    reset = 1'b1; sck = 1'b0; mosi = 1'b0; ss = 1'b1;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    clr_status = 1'b0;
`endif
    tick(3);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(2);

    // preloaded byte, single frame
    write_tx(8'hA5);
    ss_open();
    spi_frame(8'h50, W, 1'b0, '0, 1'b0);
    ss_close();
    do_ack();

    // back-to-back frames, second byte written during the first frame
    write_tx(8'h3C);
    ss_open();
    spi_frame(8'h11, W, 1'b1, 8'hC3, 1'b1);
    spi_frame(8'h22, W, 1'b0, '0, 1'b1);
    ss_close();

    // nothing to send: all zeros, underrun
    ss_open();
    spi_frame(8'hFF, W, 1'b0, '0, 1'b1);
    ss_close();
`ifdef SPI_SLAVE_STATUS_EN
    check("underrun_empty", 32'(underrun), 32'd1);
`endif

    // two frames without ack: overwrite, overrun
    ss_open();
    spi_frame(8'h01, W, 1'b0, '0, 1'b0);
    spi_frame(8'h02, W, 1'b0, '0, 1'b0);
    ss_close();
`ifdef SPI_SLAVE_STATUS_EN
    check("overrun_set", 32'(overrun), 32'd1);
`endif
    do_ack();

    // truncated frame then a full one
    ss_open();
    spi_frame(8'hE6, 5, 1'b0, '0, 1'b0);
    ss_close();
    write_tx(8'h4B);
    ss_open();
    spi_frame(8'h77, W, 1'b0, '0, 1'b0);
    ss_close();
    check_status();

    // reset in the middle of a frame, with rx_data non-zero and buffer full
    write_tx(8'h99);
    ss_open();
    spi_frame(8'h5A, 4, 1'b1, 8'h66, 1'b0);
    reset = 1'b1;
    ss = 1'b1;
    tick(1);
    check_reset_vals("midrst");
    reset = 1'b0;
    m_tx_full = 1'b0; m_rx_valid = 1'b0; m_rx_data = '0;
    m_over = 1'b0; m_under = 1'b0;
    tick(2);
    for (int i = 0; i < 12; i++) begin
      sck = 1'b1; mosi = 1'b1;
      tick(HP);
      sck = 1'b0;
      tick(HP);
    end
    mosi = 1'b0;
    check("ss_high_rx_valid", 32'(rx_valid), 32'd0);
    check("ss_high_busy", 32'(busy), 32'd0);
    check("ss_high_miso", 32'(miso), 32'd0);
    write_tx(8'h81);
    ss_open();
    spi_frame(8'hC4, W, 1'b0, '0, 1'b1);
    ss_close();

    // randomized windows
    for (int w = 0; w < 30; w++) begin
      if ($urandom_range(1) == 1) write_tx(W'($urandom));
      ss_open();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++)
        spi_frame(W'($urandom), W, $urandom_range(1) == 1, W'($urandom),
                  $urandom_range(1) == 1);
      if ($urandom_range(3) == 0)
        spi_frame(W'($urandom), $urandom_range(1, W-1), 1'b0, '0, 1'b0);
      ss_close();
      check_status();
      if ($urandom_range(2) == 0 && m_rx_valid) do_ack();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
